// File: rtl/mfc_pkg.sv
// Shared definitions for the multi-function clock mode controller.
//   state_e    : controller state encoding, also presented on the state output
//   BTN_*      : bit positions inside the 5-bit filtered button bus
//   DISP_*     : 4-digit display source select codes
package mfc_pkg;

  typedef enum logic [2:0] {
    ST_CLOCK  = 3'd0,
    ST_TSET   = 3'd1,
    ST_ASET   = 3'd2,
    ST_SWATCH = 3'd3,
    ST_RING   = 3'd4,
    ST_GAME   = 3'd5
  } state_e;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned BTN_W   = 5;

  localparam int unsigned BTN_INC    = 0;
  localparam int unsigned BTN_DEC    = 1;
  localparam int unsigned BTN_LEFT   = 2;
  localparam int unsigned BTN_RIGHT  = 3;
  localparam int unsigned BTN_CENTER = 4;

  localparam logic [1:0] DISP_TIME  = 2'd0;
  localparam logic [1:0] DISP_ALARM = 2'd1;
  localparam logic [1:0] DISP_SWTCH = 2'd2;
  localparam logic [1:0] DISP_GAME  = 2'd3;

endpackage

// File: rtl/mode_controller_if.sv
// Bundle between the mode controller and its neighbours (switch/button filters on the
// input side, functional blocks on the output side).
//   master : the mode controller (consumes requests, drives grants and routed buttons)
//   slave  : the surrounding system (drives requests, consumes grants)
interface mode_controller_if;
  import mfc_pkg::*;

  // Requests and events
  logic               tick_1s;
  logic               sw_clock_set;
  logic               sw_alarm_set;
  logic               sw_stopwatch;
  logic               sw_alarm_on;
  logic [BTN_W-1:0]   btn;
  logic               alarm_match;
  logic               minigame_done;

  // Grants and routed controls
  logic [STATE_W-1:0] state;
  logic               count_en;
  logic               tset_en;
  logic               aset_en;
  logic               sw_en;
  logic               game_en;
  logic               ringing;
  logic [3:0]         btn_tset;
  logic [3:0]         btn_aset;
  logic               sw_start_stop;
  logic [1:0]         disp_sel;
  logic               missed_alarm;

  modport master (
    input  tick_1s, sw_clock_set, sw_alarm_set, sw_stopwatch, sw_alarm_on, btn,
           alarm_match, minigame_done,
    output state, count_en, tset_en, aset_en, sw_en, game_en, ringing, btn_tset,
           btn_aset, sw_start_stop, disp_sel, missed_alarm
  );

  modport slave (
    output tick_1s, sw_clock_set, sw_alarm_set, sw_stopwatch, sw_alarm_on, btn,
           alarm_match, minigame_done,
    input  state, count_en, tset_en, aset_en, sw_en, game_en, ringing, btn_tset,
           btn_aset, sw_start_stop, disp_sel, missed_alarm
  );

endinterface

// File: rtl/ring_timer.sv
// Counts tick_1s pulses while the alarm rings.
//   MCLK, RESET : clock, asynchronous active-high reset
//   clr         : zero the count (ring entry)
//   en          : counting allowed (ringing)
//   tick        : one-cycle second pulse
//   done        : high in the cycle whose tick brings the count to RING_TIMEOUT
module ring_timer #(
  parameter int unsigned RING_TIMEOUT = 30,
  parameter int unsigned TCW          = 6
) (
  input  logic MCLK,
  input  logic RESET,
  input  logic clr,
  input  logic en,
  input  logic tick,
  output logic done
);

  localparam logic [TCW-1:0] LastCnt = TCW'(RING_TIMEOUT - 1);

  logic [TCW-1:0] cnt_q;

  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && tick) begin
      cnt_q <= cnt_q + TCW'(1);
    end
  end

  // Flag on the reaching tick itself so the FSM can weigh it against a same-cycle center.
  assign done = en & tick & (cnt_q == LastCnt);

endmodule

// File: rtl/mode_controller.sv
// Central mode scheduler: arbitrates display source, buttons and time-counter enable
// between time-set, alarm-set, stopwatch, alarm-ring and minigame.
//   MCLK  : system clock
//   RESET : asynchronous active-high reset
//   bus   : request inputs and grant/routing outputs (mode_controller_if.master)
module mode_controller
  import mfc_pkg::*;
#(
  parameter int unsigned RING_TIMEOUT = 30,
  parameter int unsigned TCW          = 6
) (
  input logic              MCLK,
  input logic              RESET,
  mode_controller_if.master bus
);

  state_e     state_q, state_d;
  logic       match_q, primed_q, match_rise;
  logic       missed_q, missed_d;
  logic [3:0] btn_tset_q, btn_aset_q;
  logic       sw_ss_q;
  logic       tmr_clr, tmr_done;
  logic       center;

  assign center = bus.btn[BTN_CENTER];

  // primed_q masks the first cycle after reset, so a match already high at release
  // is seen as a level, not as a fresh edge.
  assign match_rise = primed_q & bus.alarm_match & ~match_q;

  ring_timer #(
    .RING_TIMEOUT (RING_TIMEOUT),
    .TCW          (TCW)
  ) u_ring_timer (
    .MCLK  (MCLK),
    .RESET (RESET),
    .clr   (tmr_clr),
    .en    (state_q == ST_RING),
    .tick  (bus.tick_1s),
    .done  (tmr_done)
  );

  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= ST_CLOCK;
      match_q    <= 1'b0;
      primed_q   <= 1'b0;
      missed_q   <= 1'b0;
      btn_tset_q <= '0;
      btn_aset_q <= '0;
      sw_ss_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      match_q    <= bus.alarm_match;
      primed_q   <= 1'b1;
      missed_q   <= missed_d;
      // Routing uses the state the pulse arrived in, not the one being entered.
      btn_tset_q <= (state_q == ST_TSET) ? bus.btn[BTN_RIGHT:BTN_INC] : 4'd0;
      btn_aset_q <= (state_q == ST_ASET) ? bus.btn[BTN_RIGHT:BTN_INC] : 4'd0;
      sw_ss_q    <= (state_q == ST_SWATCH) & center;
    end
  end

  always_comb begin
    state_d  = state_q;
    missed_d = missed_q;
    tmr_clr  = 1'b0;

    // Clear first so a set later in this block wins.
    if (state_q == ST_CLOCK && center) missed_d = 1'b0;

    unique case (state_q)
      ST_CLOCK, ST_TSET, ST_ASET, ST_SWATCH: begin
        if (bus.sw_clock_set)      state_d = ST_TSET;
        else if (bus.sw_alarm_set) state_d = ST_ASET;
        else if (bus.sw_stopwatch) state_d = ST_SWATCH;
        else                       state_d = ST_CLOCK;
        if (bus.sw_alarm_on && match_rise &&
            (state_q == ST_CLOCK || state_q == ST_SWATCH)) begin
          state_d = ST_RING;
          tmr_clr = 1'b1;
        end
      end
      ST_RING: begin
        if (center) begin
          state_d = ST_GAME;
        end else if (!bus.sw_alarm_on) begin
          state_d = ST_CLOCK;
        end else if (tmr_done) begin
          state_d  = ST_CLOCK;
          missed_d = 1'b1;
        end
      end
      ST_GAME: begin
        if (bus.minigame_done) state_d = ST_CLOCK;
      end
      default: state_d = ST_CLOCK;
    endcase
  end

  always_comb begin
    bus.disp_sel = DISP_TIME;
    unique case (state_q)
      ST_ASET:   bus.disp_sel = DISP_ALARM;
      ST_SWATCH: bus.disp_sel = DISP_SWTCH;
      ST_GAME:   bus.disp_sel = DISP_GAME;
      default:   bus.disp_sel = DISP_TIME;
    endcase
  end

  assign bus.state         = state_q;
  assign bus.count_en      = (state_q != ST_TSET);
  assign bus.tset_en       = (state_q == ST_TSET);
  assign bus.aset_en       = (state_q == ST_ASET);
  assign bus.sw_en         = (state_q == ST_SWATCH);
  assign bus.game_en       = (state_q == ST_GAME);
  assign bus.ringing       = (state_q == ST_RING);
  assign bus.btn_tset      = btn_tset_q;
  assign bus.btn_aset      = btn_aset_q;
  assign bus.sw_start_stop = sw_ss_q;
  assign bus.missed_alarm  = missed_q;

endmodule
